// File: rtl/logic_arbiter.sv
// -----------------------------------------------------------------------------
// logic_arbiter
//   Shares one bitwise `logical` unit (AND/OR/XOR/NOR) between four requesters
//   using round-robin arbitration. One operation is in flight at a time: the
//   winner's operands and op code are latched on the grant edge, evaluated for
//   one cycle, and the registered result is held under a valid/ready handshake
//   tagged with the owning requester's index.
//
//   Optional feature macro: LOGIC_ARB_FASTPATH_EN
//     When defined, a new request seen on the result handshake edge is granted
//     straight away (RESP -> EXEC), giving one operation every two cycles.
//     When undefined, every operation returns through IDLE (three cycles).
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [3:0]     per-requester request, held until its gnt is seen
//   a_bus      in   [4*N-1:0] packed A operands, requester i at [i*N +: N]
//   b_bus      in   [4*N-1:0] packed B operands, same packing
//   op_bus     in   [7:0]     packed op codes, requester i at [2*i +: 2]
//                             00 AND, 01 OR, 10 XOR, 11 NOR
//   gnt        out  [3:0]     one-hot accept pulse, one cycle (the EXEC cycle)
//   busy       out            high whenever the arbiter is not IDLE
//   res        out  [N-1:0]   registered result
//   res_id     out  [1:0]     requester owning res
//   res_valid  out            res/res_id valid
//   res_ready  in             consumer accepts the result
// -----------------------------------------------------------------------------

module logical #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic [N-1:0] y
);
    always_comb begin
        case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~(a | b);
        endcase
    end
endmodule

module logic_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] a_bus,
    input  logic [4*N-1:0] b_bus,
    input  logic [7:0]     op_bus,
    output logic [3:0]     gnt,
    output logic           busy,
    output logic [N-1:0]   res,
    output logic [1:0]     res_id,
    output logic           res_valid,
    input  logic           res_ready
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_reg;
    logic [1:0]   rr_ptr_reg;
    logic [1:0]   win_reg;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [1:0]   op_reg;

    logic [N-1:0] a_arr  [4];
    logic [N-1:0] b_arr  [4];
    logic [1:0]   op_arr [4];
    logic [1:0]   cand   [4];
    logic [3:0]   hit;
    logic [1:0]   pick_idx;
    logic         start_op;
    logic [N-1:0] logic_y;

    // Unpack the buses and build the rotated search order: candidate gi is the
    // requester gi+1 places after the last winner, so the last winner is
    // always checked last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign a_arr[gi]  = a_bus[gi*N +: N];
            assign b_arr[gi]  = b_bus[gi*N +: N];
            assign op_arr[gi] = op_bus[2*gi +: 2];
            assign cand[gi]   = rr_ptr_reg + 2'(gi + 1);
            assign hit[gi]    = req[cand[gi]];
        end
    endgenerate

    // Lowest search position with an active request wins; scanning downwards
    // lets the earliest position overwrite later ones.
    always_comb begin
        pick_idx = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) pick_idx = cand[k];
        end
    end

`ifdef LOGIC_ARB_FASTPATH_EN
    // A result handshake with a request pending starts the next op directly.
    assign start_op = (|req) &&
                      ((state_reg == IDLE) ||
                       (state_reg == RESP && res_valid && res_ready));
`else
    assign start_op = (|req) && (state_reg == IDLE);
`endif

    assign busy = (state_reg != IDLE);

    logical #(.N(N)) u_logical (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (logic_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 2'd3;      // requester 0 is searched first
            win_reg    <= 2'd0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 2'd0;
            gnt        <= 4'd0;
            res        <= '0;
            res_id     <= 2'd0;
            res_valid  <= 1'b0;
        end else if (start_op) begin
            // Operands are captured here, so later bus changes cannot disturb
            // the in-flight operation.
            a_reg      <= a_arr[pick_idx];
            b_reg      <= b_arr[pick_idx];
            op_reg     <= op_arr[pick_idx];
            win_reg    <= pick_idx;
            rr_ptr_reg <= pick_idx;
            gnt        <= 4'b0001 << pick_idx;
            res_valid  <= 1'b0;
            state_reg  <= EXEC;
        end else begin
            case (state_reg)
                EXEC: begin
                    res       <= logic_y;
                    res_id    <= win_reg;
                    res_valid <= 1'b1;
                    gnt       <= 4'd0;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_logic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_arbiter
//   Self-checking bench for logic_arbiter (default build). A transaction-level
//   reference model predicts the round-robin winner and the bitwise result from
//   the arbitration rules; directed cases are followed by randomized traffic
//   with random backpressure and in-flight operand scrambling.
// -----------------------------------------------------------------------------

module tb_logic_arbiter;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*N-1:0] a_bus;
    logic [4*N-1:0] b_bus;
    logic [7:0]     op_bus;
    logic [3:0]     gnt;
    logic           busy;
    logic [N-1:0]   res;
    logic [1:0]     res_id;
    logic           res_valid;
    logic           res_ready;

    logic [N-1:0] a_v  [4];
    logic [N-1:0] b_v  [4];
    logic [1:0]   op_v [4];

    int n_checks = 0;
    int n_fail   = 0;
    int ref_ptr  = 3;
    int txn_no   = 0;

    always #5 clk = ~clk;

    always_comb begin
        a_bus  = '0;
        b_bus  = '0;
        op_bus = '0;
        for (int i = 0; i < 4; i++) begin
            a_bus[i*N +: N]  = a_v[i];
            b_bus[i*N +: N]  = b_v[i];
            op_bus[2*i +: 2] = op_v[i];
        end
    end

    logic_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .op_bus    (op_bus),
        .gnt       (gnt),
        .busy      (busy),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] ref_logic(input logic [N-1:0] a,
                                               input logic [N-1:0] b,
                                               input logic [1:0]   op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // First asserted requester after the previous winner, wrapping modulo 4.
    function automatic int ref_pick(input logic [3:0] m, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (ptr + k) % 4;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_operands();
        for (int i = 0; i < 4; i++) begin
            a_v[i]  = N'($urandom);
            b_v[i]  = N'($urandom);
            op_v[i] = 2'($urandom);
        end
    endtask

    // One complete operation: grant, result, optional stall, handshake.
    task automatic run_txn(input logic [3:0] m, input int stall);
        int           w;
        logic [N-1:0] exp;
        logic [3:0]   g;
        w   = ref_pick(m, ref_ptr);
        exp = ref_logic(a_v[w], b_v[w], op_v[w]);
        g   = 4'b0001 << w;
        req = m;
        tick();
        check("gnt", 32'(gnt), 32'(g));
        check("busy_exec", 32'(busy), 32'd1);
        check("valid_exec", 32'(res_valid), 32'd0);
        ref_ptr = w;
        req = 4'd0;
        scramble_operands();            // must not affect the in-flight result
        tick();
        check("res_valid", 32'(res_valid), 32'd1);
        check("res", 32'(res), 32'(exp));
        check("res_id", 32'(res_id), 32'(w));
        check("gnt_clear", 32'(gnt), 32'd0);
        res_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            req = 4'($urandom);
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_res", 32'(res), 32'(exp));
            check("hold_id", 32'(res_id), 32'(w));
            check("hold_gnt", 32'(gnt), 32'd0);
        end
        req = 4'd0;
        res_ready = 1'b1;
        tick();
        check("valid_drop", 32'(res_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("res_kept", 32'(res), 32'(exp));
        txn_no++;
        $display("txn %0d: req=%b winner=%0d res=%h stall=%0d", txn_no, m, w, exp, stall);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'd0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0; b_v[i] = '0; op_v[i] = 2'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        ref_ptr = 3;

        // Single request, AND.
        a_v[0] = 8'hF0; b_v[0] = 8'h3C; op_v[0] = 2'b00;
        run_txn(4'b0001, 0);

        // All ops on requester 2.
        for (int o = 1; o < 4; o++) begin
            a_v[2] = 8'hA5; b_v[2] = 8'h0F; op_v[2] = 2'(o);
            run_txn(4'b0100, 0);
        end

        // Backpressure with toggling requests.
        run_txn(4'b1010, 5);

        // Idle cycle with no request.
        req = 4'd0;
        tick();
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_busy0", 32'(busy), 32'd0);

        // Reset during EXEC aborts asynchronously.
        req = 4'b0110;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'(4'b0001 << ref_pick(4'b0110, ref_ptr)));
        #1 rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_res", 32'(res), 32'd0);
        #1 rst = 1'b0;
        req = 4'd0;
        ref_ptr = 3;
        tick();
        check("post_rst_valid", 32'(res_valid), 32'd0);

        // Round-robin with all four holding req.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int           w;
            logic [N-1:0] exp;
            w   = ref_pick(4'b1111, ref_ptr);
            exp = ref_logic(a_v[w], b_v[w], op_v[w]);
            tick();
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << w));
            ref_ptr = w;
            tick();
            check("rr_id", 32'(res_id), 32'(w));
            check("rr_res", 32'(res), 32'(exp));
            check("rr_valid", 32'(res_valid), 32'd1);
            tick();
            check("rr_hs", 32'(res_valid), 32'd0);
            check("rr_gnt0", 32'(gnt), 32'd0);
            scramble_operands();
            txn_no++;
            $display("txn %0d: rr winner=%0d res=%h", txn_no, w, exp);
        end
        req = 4'd0;
        tick();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            scramble_operands();
            if ($urandom_range(0, 4) == 0) begin
                req = 4'd0;
                tick();
                check("rnd_idle_gnt", 32'(gnt), 32'd0);
                check("rnd_idle_busy", 32'(busy), 32'd0);
            end else begin
                run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
